// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the instruction buffer slice.
// sys_defs carries the machine-wide types (INST, IB_ENTRY, IB_DEPTH);
// inst_buffer_pkg carries widths derived from the fetch width.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;
  typedef logic [31:0] INST;

  // One buffered instruction: its fetch PC and the raw word
  typedef struct packed {
    logic [`XLEN-1:0] PC;
    INST              inst;
  } IB_ENTRY;

  localparam int IB_DEPTH = 8;
endpackage

package inst_buffer_pkg;
  // Width of dispatch_num and of a per-group lane count (0..N_WAY)
  localparam int IB_DN_W   = $clog2(`N_WAY + 1);
  // Width of a lane index (0..N_WAY-1)
  localparam int IB_LANE_W = (`N_WAY > 1) ? $clog2(`N_WAY) : 1;
endpackage

// File: rtl/inst_buffer_if.sv
// Fetch-side and decode-side signals of the instruction buffer.
// master = fetch/decode environment, slave = the buffer itself.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface inst_buffer_if
  import sys_defs::*;
#(
  parameter int DEPTH = IB_DEPTH
);
  logic                               flush;
  logic [`N_WAY-1:0][`XLEN-1:0]       in_PC;
  INST  [`N_WAY-1:0]                  in_inst;
  logic [`N_WAY-1:0]                  in_valid;
  logic                               in_ready;
  logic [$clog2(`N_WAY+1)-1:0]        dispatch_num;
  logic [`N_WAY-1:0][`XLEN-1:0]       out_PC;
  INST  [`N_WAY-1:0]                  out_inst;
  logic [`N_WAY-1:0]                  out_valid;
  logic [$clog2(DEPTH+1)-1:0]         count;

  modport master (
    output flush, in_PC, in_inst, in_valid, dispatch_num,
    input  in_ready, out_PC, out_inst, out_valid, count
  );

  modport slave (
    input  flush, in_PC, in_inst, in_valid, dispatch_num,
    output in_ready, out_PC, out_inst, out_valid, count
  );
endinterface

// File: rtl/inst_buffer_lane_compactor.sv
// lane_compactor: counts the valid fetch lanes and, for every compacted
// slot j, reports which input lane supplies it (ascending lane order).
`ifndef N_WAY
`define N_WAY 2
`endif

module lane_compactor #(
  parameter  int N  = `N_WAY,
  localparam int CW = $clog2(N + 1),
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         valid,
  output logic [CW-1:0]        popcnt,
  output logic [N-1:0][IW-1:0] src_idx
);
  // prefix[i] = number of valid lanes strictly below lane i
  logic [N:0][CW-1:0] prefix;

  assign prefix[0] = '0;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_prefix
      assign prefix[gi+1] = prefix[gi] + CW'(valid[gi]);
    end
  endgenerate

  assign popcnt = prefix[N];

  // Scatter each valid lane's index into the slot given by its prefix
  always_comb begin
    src_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i]) src_idx[prefix[i][IW-1:0]] = IW'(i);
    end
  end
endmodule

// File: rtl/inst_buffer.sv
// inst_buffer: circular FIFO between fetch and decode. Accepts up to N_WAY
// compacted instructions per cycle and presents the oldest N_WAY entries.
// Optional feature macro: INST_BUFFER_BYPASS_EN -- when the buffer is empty,
// incoming lanes are shown on the outputs in the same cycle and may be
// consumed without ever being written to storage.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

module inst_buffer
  import sys_defs::*;
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  inst_buffer_if.slave ib
);
  localparam int N  = `N_WAY;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = IB_DN_W;
  localparam int IW = IB_LANE_W;

  IB_ENTRY         mem [DEPTH];
  logic [PW-1:0]   head_reg, head_next;
  logic [PW-1:0]   tail_reg, tail_next;
  logic [CW-1:0]   count_reg, count_next;

  logic [DW-1:0]         popcnt;
  logic [N-1:0][IW-1:0]  src_idx;

  logic                  ready;
  logic                  push_fire;
  logic                  byp;
  logic [DW-1:0]         consume;
  logic [CW-1:0]         pushed;
  logic [CW-1:0]         pop;
  logic [N-1:0]          wr_en;
  logic [N-1:0][PW-1:0]  wr_addr;
  IB_ENTRY [N-1:0]       wr_data;
  logic                  lane_valid;
  IB_ENTRY               lane_data;

  lane_compactor #(.N(N)) u_compactor (
    .valid   (ib.in_valid),
    .popcnt  (popcnt),
    .src_idx (src_idx)
  );

  // Occupancy bookkeeping, storage write selection and output lane muxing
  always_comb begin
    ready     = (count_reg <= CW'(DEPTH - N));
    push_fire = ready && (|ib.in_valid);
    pop       = (CW'(ib.dispatch_num) > count_reg) ? count_reg : CW'(ib.dispatch_num);

`ifdef INST_BUFFER_BYPASS_EN
    byp = (count_reg == '0) && !ib.flush && !reset;
`else
    byp = 1'b0;
`endif
    // Lanes eaten straight from the fetch group while bypassing
    consume = '0;
    if (byp) consume = (ib.dispatch_num > popcnt) ? popcnt : ib.dispatch_num;
    pushed  = push_fire ? (CW'(popcnt) - CW'(consume)) : '0;

    // Compacted slot j lands at tail + (j - consume) unless consumed
    for (int j = 0; j < N; j++) begin
      wr_data[j] = '{PC: ib.in_PC[src_idx[j]], inst: ib.in_inst[src_idx[j]]};
      wr_en[j]   = push_fire && (DW'(j) < popcnt) && (DW'(j) >= consume);
      wr_addr[j] = tail_reg + PW'(j) - PW'(consume);
    end

    head_next  = head_reg + PW'(pop);
    tail_next  = tail_reg + PW'(pushed);
    count_next = count_reg + pushed - pop;

    // A mispredict empties the buffer and drops this cycle's fetch group
    if (ib.flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
      wr_en      = '0;
    end

    ib.in_ready = ready;
    ib.count    = count_reg;
    for (int i = 0; i < N; i++) begin
      if (byp) begin
        lane_valid = DW'(i) < popcnt;
        lane_data  = wr_data[i];
      end else begin
        lane_valid = CW'(i) < count_reg;
        lane_data  = mem[head_reg + PW'(i)];
      end
      ib.out_valid[i] = lane_valid;
      ib.out_PC[i]    = lane_valid ? lane_data.PC   : '0;
      ib.out_inst[i]  = lane_valid ? lane_data.inst : '0;
    end
  end

  // Pointer/occupancy registers and entry storage (storage is never reset)
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      for (int j = 0; j < N; j++) begin
        if (wr_en[j]) mem[wr_addr[j]] <= wr_data[j];
      end
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Testbench for inst_buffer: a queue-based reference model acts as the
// scoreboard, plus a vector table and hand-written corner-case sequences.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_inst_buffer;
  import sys_defs::*;

  localparam int N     = `N_WAY;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_buffer_if #(.DEPTH(DEPTH)) ib();

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock (clk),
    .reset (rst),
    .ib    (ib.slave)
  );

  IB_ENTRY     q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] pcb   = 32'h1000;

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] dn;
    logic          fl;
    int            exp_cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic INST inst_of(input logic [31:0] pc);
    return INST'(pc ^ 32'hA5A5_0000);
  endfunction

  // Drive one cycle of traffic, compare outputs to the model, advance the model
  task automatic step(input logic [N-1:0] v, input logic [DW-1:0] dn, input logic fl,
                      input logic [31:0] base, input string tag);
    IB_ENTRY grp[$];
    IB_ENTRY e;
    int      sz;
    int      take;
    bit      have;
    bit      byp;
    @(negedge clk);
    ib.in_valid     = v;
    ib.dispatch_num = dn;
    ib.flush        = fl;
    for (int i = 0; i < N; i++) begin
      ib.in_PC[i]   = base + 32'(4 * i);
      ib.in_inst[i] = inst_of(base + 32'(4 * i));
      if (v[i]) grp.push_back('{PC: base + 32'(4 * i), inst: inst_of(base + 32'(4 * i))});
    end
    #1;
    sz  = q.size();
    byp = 1'b0;
`ifdef INST_BUFFER_BYPASS_EN
    byp = (sz == 0) && !fl;
`endif
    check($sformatf("%s.count", tag), 64'(ib.count), 64'(sz));
    check($sformatf("%s.ready", tag), 64'(ib.in_ready), 64'(sz <= DEPTH - N));
    for (int i = 0; i < N; i++) begin
      if (byp) have = (i < grp.size());
      else     have = (i < sz);
      e = '0;
      if (have) e = byp ? grp[i] : q[i];
      check($sformatf("%s.valid%0d", tag, i), 64'(ib.out_valid[i]), 64'(have));
      check($sformatf("%s.pc%0d", tag, i), 64'(ib.out_PC[i]), 64'(e.PC));
      check($sformatf("%s.inst%0d", tag, i), 64'(ib.out_inst[i]), 64'(e.inst));
    end
    $display("[TB] %s v=%b dn=%0d fl=%b count=%0d", tag, v, dn, fl, ib.count);
    if (fl) begin
      q.delete();
    end else if (byp) begin
      take = (int'(dn) < grp.size()) ? int'(dn) : grp.size();
      for (int k = take; k < grp.size(); k++) q.push_back(grp[k]);
    end else begin
      take = (int'(dn) < sz) ? int'(dn) : sz;
      repeat (take) void'(q.pop_front());
      if (sz <= DEPTH - N) foreach (grp[k]) q.push_back(grp[k]);
    end
  endtask

  task automatic stepn(input logic [N-1:0] v, input logic [DW-1:0] dn, input logic fl,
                       input string tag);
    step(v, dn, fl, pcb, tag);
    pcb = pcb + 32'h10;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] v, input logic [DW-1:0] dn);
    @(negedge clk);
    rst             = 1'b1;
    ib.in_valid     = v;
    ib.dispatch_num = dn;
    ib.flush        = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    ib.in_valid     = '0;
    ib.dispatch_num = '0;
    #1;
    check("reset.count", 64'(ib.count), 64'd0);
    check("reset.ready", 64'(ib.in_ready), 64'd1);
    check("reset.valid", 64'(ib.out_valid), 64'd0);
    check("reset.pc0", 64'(ib.out_PC[0]), 64'd0);
    check("reset.inst0", 64'(ib.out_inst[0]), 64'd0);
  endtask

  initial begin
    tbl[0] = '{v: 2'b11, dn: 2'd0, fl: 1'b0, exp_cnt: 2};
    tbl[1] = '{v: 2'b01, dn: 2'd0, fl: 1'b0, exp_cnt: 3};
    tbl[2] = '{v: 2'b11, dn: 2'd0, fl: 1'b0, exp_cnt: 5};
    tbl[3] = '{v: 2'b11, dn: 2'd0, fl: 1'b0, exp_cnt: 7};
    tbl[4] = '{v: 2'b11, dn: 2'd0, fl: 1'b0, exp_cnt: 7};
    tbl[5] = '{v: 2'b00, dn: 2'd2, fl: 1'b0, exp_cnt: 5};
    tbl[6] = '{v: 2'b10, dn: 2'd1, fl: 1'b0, exp_cnt: 5};
    tbl[7] = '{v: 2'b11, dn: 2'd2, fl: 1'b1, exp_cnt: 0};
    tbl[8] = '{v: 2'b00, dn: 2'd2, fl: 1'b0, exp_cnt: 0};

    ib.flush        = 1'b0;
    ib.in_valid     = '0;
    ib.dispatch_num = '0;
    ib.in_PC        = '0;
    ib.in_inst      = '0;
    repeat (2) @(posedge clk);
    do_reset('0, '0);

    // Full group after reset appears one cycle later
    step(2'b11, 2'd0, 1'b0, 32'h0, "r037");
    after_edge();
    check("r037.valid", 64'(ib.out_valid), 64'h3);
    check("r037.pc0", 64'(ib.out_PC[0]), 64'h0);
    check("r037.pc1", 64'(ib.out_PC[1]), 64'h4);
    check("r037.count", 64'(ib.count), 64'd2);
    stepn(2'b00, 2'd2, 1'b0, "r037_drain");

    // Single lane-1 instruction lands in slot 0
    step(2'b10, 2'd0, 1'b0, 32'h100, "r038");
    after_edge();
    check("r038.pc0", 64'(ib.out_PC[0]), 64'h104);
    check("r038.count", 64'(ib.count), 64'd1);
    check("r038.valid", 64'(ib.out_valid), 64'h1);

    // Dispatch more than present pops only what is there
    stepn(2'b00, 2'd2, 1'b0, "r042_pop");
    after_edge();
    check("r042.count", 64'(ib.count), 64'd0);

    // Fill to full, reject a push, then free space
    for (int k = 0; k < 4; k++) stepn(2'b11, 2'd0, 1'b0, "r039_fill");
    after_edge();
    check("r039.full_count", 64'(ib.count), 64'd8);
    check("r039.full_ready", 64'(ib.in_ready), 64'd0);
    stepn(2'b11, 2'd0, 1'b0, "r039_ign");
    after_edge();
    check("r039.ign_count", 64'(ib.count), 64'd8);
    stepn(2'b00, 2'd2, 1'b0, "r039_pop");
    after_edge();
    check("r039.pop_count", 64'(ib.count), 64'd6);
    check("r039.pop_ready", 64'(ib.in_ready), 64'd1);
    for (int k = 0; k < 3; k++) stepn(2'b00, 2'd2, 1'b0, "r039_drain");

    // Vector table
    for (int k = 0; k < 9; k++) begin
      stepn(tbl[k].v, tbl[k].dn, tbl[k].fl, $sformatf("tbl%0d", k));
      after_edge();
      check($sformatf("tbl%0d.exp_count", k), 64'(ib.count), 64'(tbl[k].exp_cnt));
    end

    // Flush with push and pop in the same cycle
    stepn(2'b11, 2'd0, 1'b0, "r041_pre");
    stepn(2'b11, 2'd2, 1'b1, "r041");
    after_edge();
    check("r041.count", 64'(ib.count), 64'd0);
    check("r041.valid", 64'(ib.out_valid), 64'd0);

    // Random traffic wraps the pointers several times
    for (int k = 0; k < 20; k++) begin
      stepn(N'($urandom), DW'($urandom_range(0, N)), 1'b0, $sformatf("r040_%0d", k));
    end
    for (int k = 0; k < 5; k++) stepn(2'b00, 2'd2, 1'b0, "r040_drain");

    // Reset mid-operation with traffic present
    stepn(2'b11, 2'd0, 1'b0, "rst_pre0");
    stepn(2'b01, 2'd0, 1'b0, "rst_pre1");
    do_reset(2'b11, 2'd1);

`ifdef INST_BUFFER_BYPASS_EN
    // Empty buffer: group is visible and consumed in the same cycle
    step(2'b11, 2'd2, 1'b0, 32'h200, "byp");
    @(negedge clk);
    ib.in_valid     = 2'b11;
    ib.dispatch_num = 2'd2;
    #1;
    check("byp.same_valid", 64'(ib.out_valid), 64'h3);
    check("byp.same_count", 64'(ib.count), 64'd0);
    after_edge();
    check("byp.after_count", 64'(ib.count), 64'd0);
    ib.in_valid     = '0;
    ib.dispatch_num = '0;
    step(2'b11, 2'd1, 1'b0, 32'h300, "byp_part");
`endif

    stepn(2'b00, 2'd0, 1'b0, "final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of instruction entries; it SHALL be a power of two and at least 2*`N_WAY.
REQ-002 The block SHALL have port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port flush, input, 1 bit: on a mispredict, discard all entries.
REQ-005 The block SHALL have port in_PC, input, [`N_WAY-1:0][`XLEN-1:0]: PCs of the fetched lanes.
REQ-006 The block SHALL have port in_inst, input, INST[`N_WAY-1:0]: fetched instruction words.
REQ-007 The block SHALL have port in_valid, input, [`N_WAY-1:0]: per-lane fetch valid; any bit pattern is legal.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the buffer accepts a fetch group this cycle.
REQ-009 The block SHALL have port dispatch_num, input, $clog2(`N_WAY+1) bits: the number of head entries the decoder consumes this cycle.
REQ-010 The block SHALL have port out_PC, output, [`N_WAY-1:0][`XLEN-1:0]: PCs of the oldest `N_WAY entries.
REQ-011 The block SHALL have port out_inst, output, INST[`N_WAY-1:0]: instructions of the oldest entries; lane 0 holds the oldest.
REQ-012 The block SHALL have port out_valid, output, [`N_WAY-1:0]: thermometer mask; bit i is 1 iff count > i.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits: the current occupancy.

Function
REQ-014 The block SHALL be a circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-015 in_ready SHALL be 1 iff (DEPTH - count) >= `N_WAY, using registered count only; same-cycle pops SHALL NOT be credited.
REQ-016 Push SHALL occur iff in_ready and |in_valid; valid lanes are compacted in ascending lane order into tail, tail+1, ..., and tail advances by popcount(in_valid).
REQ-017 When in_ready = 0, in_valid SHALL be ignored and no state SHALL change from the push side.
REQ-018 The effective pop SHALL be min(dispatch_num, count), taken from the registered count; head advances by the effective pop.
REQ-019 On a simultaneous push and pop, count_next SHALL equal count + pushed - popped, and both pointers SHALL update in the same cycle.
REQ-020 Outputs SHALL be registered-path reads: out_PC[i] and out_inst[i] come from entry head+i (mod DEPTH); lanes with out_valid[i] = 0 SHALL be driven to 0.
REQ-021 Without bypass, write-to-visible latency SHALL be 1 cycle: an entry pushed at edge k appears on the outputs after edge k.
REQ-022 flush SHALL take priority over push and pop; on the next edge head = tail = 0 and count = 0, and the same-cycle push is dropped.
REQ-023 Full (count = DEPTH) and empty (count = 0) SHALL be distinguished by count, not by pointer equality.

Reset
REQ-024 When reset = 1 at a clock edge, head, tail, and count SHALL be 0, out_valid SHALL be 0, out_PC and out_inst SHALL be 0, and in_ready SHALL be 1.
REQ-025 Entry storage SHALL NOT require reset.
REQ-026 Reset SHALL dominate flush and all traffic.
REQ-027 Reset asserted mid-operation SHALL discard all contents in the same edge.

Configuration
REQ-028 The macro INST_BUFFER_BYPASS_EN SHALL select bypass behaviour.
REQ-029 When INST_BUFFER_BYPASS_EN is defined and count = 0 with flush = 0, valid incoming lanes SHALL appear compacted on the outputs in the same cycle, and dispatch_num SHALL consume them directly.
REQ-030 Under bypass, consumed lanes SHALL NOT be written to storage; unconsumed lanes SHALL be written in order.
REQ-031 Under bypass, the same-cycle consume SHALL be min(dispatch_num, popcount(in_valid)).
REQ-032 When INST_BUFFER_BYPASS_EN is undefined, the 1-cycle latency of REQ-021 SHALL always apply.

Structure
REQ-033 `N_WAY, `XLEN, and INST SHALL come from the shared sys_defs package.
REQ-034 A typedef IB_ENTRY {PC, inst} and the constant IB_DEPTH SHALL be added to sys_defs.
REQ-035 One sub-module, lane_compactor, SHALL be instantiated to produce popcount and the compacted lane index for in_valid.
REQ-036 The block SHALL otherwise be a single always_ff plus always_comb.

Verification
REQ-037 Verification SHALL cover this scenario: reset, then push in_valid = all-ones with PCs 0x0, 0x4, ... -> next cycle out_valid = all-ones, out_PC[0] = 0x0, and count = `N_WAY.
REQ-038 Verification SHALL cover this scenario: in_valid = 2'b10 (N_WAY = 2) with PC 0x104 on lane 1 -> stored in lane 0 position, out_PC[0] = 0x104, and count increments by 1.
REQ-039 Verification SHALL cover this scenario: fill to DEPTH = 8 -> in_ready = 0, and a further push is ignored with count held at 8; then dispatch_num = 2 -> count = 6 and in_ready = 1.
REQ-040 Verification SHALL cover this scenario: 20 push/pop cycles forcing pointer wrap -> output order matches a reference queue exactly.
REQ-041 Verification SHALL cover this scenario: flush together with push and dispatch_num = 2 -> next cycle count = 0, out_valid = 0, and the pushed group is lost.
REQ-042 Verification SHALL cover this scenario: dispatch_num = 2 with count = 1 -> effective pop = 1 and count = 0; and, with INST_BUFFER_BYPASS_EN, empty buffer plus push plus dispatch_num = `N_WAY -> same-cycle out_valid = all-ones and count stays 0.
